// File: rtl/audio_pkg.sv
// Shared definitions for the audio control path: the transport state encoding
// and the default WM8731 configuration sequence.
package audio_pkg;

   typedef enum logic [3:0] {
      S_IDLE       = 4'd0,
      S_INIT_SEND  = 4'd1,
      S_INIT_WAIT  = 4'd2,
      S_STOP       = 4'd3,
      S_RECORD     = 4'd4,
      S_REC_PAUSE  = 4'd5,
      S_PLAY       = 4'd6,
      S_PLAY_PAUSE = 4'd7,
      S_ERROR      = 4'd8
   } state_e;

   localparam int unsigned WM_N_INIT = 6;
   localparam int unsigned WM_CFG_W  = 24;

   // {I2C write address, register address + data bit 8, data bits 7:0}
   localparam logic [23:0] WM_ANALOG_PATH  = 24'h34_08_15;
   localparam logic [23:0] WM_DIGITAL_PATH = 24'h34_0A_00;
   localparam logic [23:0] WM_POWER_DOWN   = 24'h34_0C_00;
   localparam logic [23:0] WM_FORMAT       = 24'h34_0E_02;
   localparam logic [23:0] WM_SAMPLING     = 24'h34_10_00;
   localparam logic [23:0] WM_ACTIVE       = 24'h34_12_01;

   // Word 0 sits in the least significant bits and is sent first.
   localparam logic [WM_N_INIT*WM_CFG_W-1:0] WM_INIT_WORDS = {
      WM_ACTIVE, WM_SAMPLING, WM_FORMAT, WM_POWER_DOWN, WM_DIGITAL_PATH, WM_ANALOG_PATH
   };

endpackage

// File: rtl/init_seq.sv
// Codec init sequencer: walks the config words, issues I2C start pulses and
// tracks NACK retries; the transport FSM decides when it may send or listen.
module init_seq
   import audio_pkg::*;
#(
   parameter int unsigned N_INIT    = 6,
   parameter int unsigned CFG_W     = 24,
   parameter int unsigned MAX_RETRY = 3
) (
   input  logic                    clk_i,
   input  logic                    rst_ni,
   input  logic [N_INIT*CFG_W-1:0] init_data_i,
   input  logic                    clr_i,
   input  logic                    send_i,
   input  logic                    wait_i,
   input  logic                    finished_i,
   input  logic                    nack_i,
   output logic                    start_o,
   output logic [CFG_W-1:0]        dat_o,
   output logic                    all_sent_o,
   output logic                    advance_o,
   output logic                    err_o
);

   localparam int unsigned IDX_W = $clog2(N_INIT + 1);
   localparam int unsigned RTY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

   logic [IDX_W-1:0] idx_q, idx_d;
   logic [RTY_W-1:0] rty_q, rty_d;
   logic             start_q, start_d;
   logic [CFG_W-1:0] dat_q, dat_d;
   logic             retry_left;
   logic             word_end;

   assign all_sent_o = (idx_q == IDX_W'(N_INIT));
   assign retry_left = (rty_q != RTY_W'(MAX_RETRY));
   assign word_end   = wait_i & finished_i;
   assign advance_o  = word_end & (~nack_i | retry_left);
   assign err_o      = word_end & nack_i & ~retry_left;

   always_comb begin
      idx_d   = idx_q;
      rty_d   = rty_q;
      start_d = 1'b0;
      dat_d   = dat_q;
      if (clr_i) begin
         idx_d = '0;
         rty_d = '0;
      end else if (send_i && !all_sent_o) begin
         start_d = 1'b1;
         dat_d   = init_data_i[idx_q*CFG_W +: CFG_W];
      end else if (word_end) begin
         if (!nack_i) begin
            idx_d = idx_q + 1'b1;
            rty_d = '0;
         end else if (retry_left) begin
            rty_d = rty_q + 1'b1;
         end
      end
   end

   // dat_q is only reloaded on a start, so it stays stable until the sender finishes.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         idx_q   <= '0;
         rty_q   <= '0;
         start_q <= 1'b0;
         dat_q   <= '0;
      end else begin
         idx_q   <= idx_d;
         rty_q   <= rty_d;
         start_q <= start_d;
         dat_q   <= dat_d;
      end
   end

   assign start_o = start_q;
   assign dat_o   = dat_q;

endmodule

// File: rtl/codec_transport_ctrl.sv
// Audio top-level control: codec init over I2C, then a record/play/pause/stop
// transport that drives the sample-memory address and remembers the clip length.
module codec_transport_ctrl
   import audio_pkg::*;
#(
   parameter int unsigned N_INIT    = 6,
   parameter int unsigned CFG_W     = 24,
   parameter int unsigned ADDR_W    = 20,
   parameter int unsigned MAX_RETRY = 3
) (
   input  logic                    i_clk,
   input  logic                    i_rst,
   input  logic [N_INIT*CFG_W-1:0] i_init_data,
   input  logic                    i_power,
   input  logic                    i_run,
   input  logic                    i_rec_sel,
   input  logic                    i_play_sel,
   input  logic                    i_sample_tick,
   input  logic                    i_i2c_finished,
   input  logic                    i_i2c_nack,
   output logic                    o_i2c_start,
   output logic [CFG_W-1:0]        o_i2c_dat,
   output logic [3:0]              o_state,
   output logic [ADDR_W-1:0]       o_addr,
   output logic [ADDR_W:0]         o_rec_len,
   output logic                    o_rec_en,
   output logic                    o_play_en,
   output logic                    o_init_done,
   output logic                    o_init_err
);

   localparam logic [ADDR_W:0] LEN_LAST = {1'b0, {ADDR_W{1'b1}}};

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [ADDR_W:0]   len_q, len_d;
   logic              done_q, done_d;
   logic              rec_en_q, play_en_q, err_q;
   logic              seq_all_sent, seq_advance, seq_err;
   logic              rec_only, play_only, clip_end;

   assign rec_only  = i_rec_sel & ~i_play_sel;
   assign play_only = i_play_sel & ~i_rec_sel;
   assign clip_end  = ({1'b0, addr_q} == (len_q - 1'b1));

   init_seq #(
      .N_INIT    (N_INIT),
      .CFG_W     (CFG_W),
      .MAX_RETRY (MAX_RETRY)
   ) u_init_seq (
      .clk_i       (i_clk),
      .rst_ni      (i_rst),
      .init_data_i (i_init_data),
      .clr_i       ((state_q == S_IDLE) & i_power),
      .send_i      ((state_q == S_INIT_SEND) & i_power),
      .wait_i      ((state_q == S_INIT_WAIT) & i_power),
      .finished_i  (i_i2c_finished),
      .nack_i      (i_i2c_nack),
      .start_o     (o_i2c_start),
      .dat_o       (o_i2c_dat),
      .all_sent_o  (seq_all_sent),
      .advance_o   (seq_advance),
      .err_o       (seq_err)
   );

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      len_d   = len_q;
      done_d  = done_q;
      if (state_q != S_IDLE && !i_power) begin
         state_d = S_IDLE;
         done_d  = 1'b0;
      end else begin
         unique case (state_q)
            S_IDLE:       if (i_power) state_d = S_INIT_SEND;
            S_INIT_SEND: begin
               if (seq_all_sent) begin
                  state_d = S_STOP;
                  done_d  = 1'b1;
               end else begin
                  state_d = S_INIT_WAIT;
               end
            end
            S_INIT_WAIT: begin
               if (seq_err)          state_d = S_ERROR;
               else if (seq_advance) state_d = S_INIT_SEND;
            end
            S_STOP: begin
               if (i_run && rec_only) begin
                  state_d = S_RECORD;
                  len_d   = '0;
               end else if (i_run && play_only && len_q != '0) begin
                  state_d = S_PLAY;
               end
            end
            S_RECORD: begin
               // A sample that arrives while leaving is still counted.
               if (i_sample_tick) begin
                  addr_d = addr_q + 1'b1;
                  len_d  = len_q + 1'b1;
               end
               if (!rec_only)                              state_d = S_STOP;
               else if (i_sample_tick && len_q == LEN_LAST) state_d = S_STOP;
               else if (!i_run)                            state_d = S_REC_PAUSE;
            end
            S_REC_PAUSE: begin
               if (!rec_only)  state_d = S_STOP;
               else if (i_run) state_d = S_RECORD;
            end
            S_PLAY: begin
               if (i_sample_tick) addr_d = addr_q + 1'b1;
               if (!play_only)                     state_d = S_STOP;
               else if (i_sample_tick && clip_end) state_d = S_STOP;
               else if (!i_run)                    state_d = S_PLAY_PAUSE;
            end
            S_PLAY_PAUSE: begin
               if (!play_only) state_d = S_STOP;
               else if (i_run) state_d = S_PLAY;
            end
            S_ERROR:      state_d = S_ERROR;
            default:      state_d = S_IDLE;
         endcase
      end
      // Address is zero whenever the transport is parked.
      if (state_d == S_STOP || state_d == S_IDLE) addr_d = '0;
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         state_q   <= S_IDLE;
         addr_q    <= '0;
         len_q     <= '0;
         done_q    <= 1'b0;
         rec_en_q  <= 1'b0;
         play_en_q <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         len_q     <= len_d;
         done_q    <= done_d;
         rec_en_q  <= (state_d == S_RECORD);
         play_en_q <= (state_d == S_PLAY);
         err_q     <= (state_d == S_ERROR);
      end
   end

   assign o_state     = state_q;
   assign o_addr      = addr_q;
   assign o_rec_len   = len_q;
   assign o_rec_en    = rec_en_q;
   assign o_play_en   = play_en_q;
   assign o_init_done = done_q;
   assign o_init_err  = err_q;

endmodule

// File: tb/tb_codec_transport_ctrl.sv
// Bench for codec_transport_ctrl with a 4-bit address so memory-full is reachable;
// an I2C responder model answers start pulses from a NACK plan.
module tb_codec_transport_ctrl;
   import audio_pkg::*;

   localparam int N_INIT = 6, CFG_W = 24, ADDR_W = 4, MAX_RETRY = 3;
   localparam logic [3:0] ST_IDLE = 4'd0, ST_STOP = 4'd3, ST_REC = 4'd4, ST_RPAUSE = 4'd5;
   localparam logic [3:0] ST_PLAY = 4'd6, ST_PPAUSE = 4'd7, ST_ERR = 4'd8;

   logic clk = 1'b0;
   logic rst_n, power, run, rec_sel, play_sel, tick;
   logic fin = 1'b0, nack = 1'b0;
   logic [N_INIT*CFG_W-1:0] init_data;
   logic                    i2c_start;
   logic [CFG_W-1:0]        i2c_dat;
   logic [3:0]              state;
   logic [ADDR_W-1:0]       addr;
   logic [ADDR_W:0]         rec_len;
   logic                    rec_en, play_en, init_done, init_err;

   int total = 0, bad = 0;
   logic [CFG_W-1:0] got_q[$], exp_q[$];
   logic             nack_plan[$];

   always #5 clk = ~clk;

   codec_transport_ctrl #(
      .N_INIT(N_INIT), .CFG_W(CFG_W), .ADDR_W(ADDR_W), .MAX_RETRY(MAX_RETRY)
   ) dut (
      .i_clk(clk), .i_rst(rst_n), .i_init_data(init_data), .i_power(power),
      .i_run(run), .i_rec_sel(rec_sel), .i_play_sel(play_sel), .i_sample_tick(tick),
      .i_i2c_finished(fin), .i_i2c_nack(nack), .o_i2c_start(i2c_start),
      .o_i2c_dat(i2c_dat), .o_state(state), .o_addr(addr), .o_rec_len(rec_len),
      .o_rec_en(rec_en), .o_play_en(play_en), .o_init_done(init_done),
      .o_init_err(init_err)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic chk_state(input string tag, input logic [3:0] exp);
      chk({tag, ".state"}, state, exp);
      chk({tag, ".rec_en"}, rec_en, exp == ST_REC);
      chk({tag, ".play_en"}, play_en, exp == ST_PLAY);
      chk({tag, ".init_err"}, init_err, exp == ST_ERR);
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic pulse_tick();
      tick = 1'b1;
      @(negedge clk);
      tick = 1'b0;
   endtask

   task automatic gap();
      repeat ($urandom_range(0, 2)) @(negedge clk);
   endtask

   task automatic wait_state(input string tag, input logic [3:0] exp, input int budget);
      int n = 0;
      while (state !== exp && n < budget) begin
         @(negedge clk);
         n++;
      end
      chk(tag, state, exp);
   endtask

   task automatic check_words(input string tag);
      chk({tag, ".count"}, got_q.size(), exp_q.size());
      while (exp_q.size() > 0 && got_q.size() > 0)
         chk({tag, ".word"}, got_q.pop_front(), exp_q.pop_front());
      got_q.delete();
      exp_q.delete();
   endtask

   always @(negedge clk)
      if (i2c_start === 1'b1) got_q.push_back(i2c_dat);

   always begin : responder
      logic [CFG_W-1:0] w;
      logic             nk;
      @(negedge clk);
      if (i2c_start === 1'b1) begin
         w  = i2c_dat;
         nk = (nack_plan.size() > 0) ? nack_plan.pop_front() : 1'b0;
         repeat ($urandom_range(2, 5)) @(negedge clk);
         chk("dat_held", i2c_dat, w);
         fin  = 1'b1;
         nack = nk;
         @(negedge clk);
         fin  = 1'b0;
         nack = 1'b0;
      end
   end

   initial begin
      int m_len, m_pos, k, nn, p, n1, n2, att, wt;
      rst_n = 1'b0; power = 1'b0; run = 1'b0; rec_sel = 1'b0; play_sel = 1'b0; tick = 1'b0;
      init_data = WM_INIT_WORDS;
      cyc(3);
      chk_state("rst", ST_IDLE);
      chk("rst.addr", addr, 0);
      chk("rst.len", rec_len, 0);
      chk("rst.start", i2c_start, 0);
      chk("rst.dat", i2c_dat, 0);
      chk("rst.done", init_done, 0);
      rst_n = 1'b1;
      cyc(2);
      chk_state("idle_hold", ST_IDLE);

      // Power-up with every word ACKed: words go out once each, in order.
      for (int i = 0; i < N_INIT; i++) exp_q.push_back(init_data[i*CFG_W +: CFG_W]);
      power = 1'b1;
      wait_state("init_ack", ST_STOP, 400);
      chk("init_ack.done", init_done, 1);
      chk("init_ack.addr", addr, 0);
      check_words("init_ack");
      power = 1'b0;
      cyc(1);
      chk_state("pwr_off", ST_IDLE);
      chk("pwr_off.done", init_done, 0);

      // Random word NACKed 1..MAX_RETRY times: it repeats until ACKed.
      for (int i = 0; i < N_INIT; i++) init_data[i*CFG_W +: CFG_W] = CFG_W'($urandom);
      k  = $urandom_range(0, N_INIT - 1);
      nn = $urandom_range(1, MAX_RETRY);
      for (int i = 0; i < N_INIT; i++) begin
         att = (i == k) ? nn + 1 : 1;
         for (int a = 0; a < att; a++) begin
            exp_q.push_back(init_data[i*CFG_W +: CFG_W]);
            nack_plan.push_back(a != att - 1);
         end
      end
      power = 1'b1;
      wait_state("init_retry", ST_STOP, 600);
      chk("init_retry.done", init_done, 1);
      chk("init_retry.plan_used", nack_plan.size(), 0);
      check_words("init_retry");
      power = 1'b0;
      cyc(1);

      // One word NACKed MAX_RETRY+1 times: error, and no further starts.
      k = $urandom_range(0, N_INIT - 1);
      for (int i = 0; i < k; i++) begin
         exp_q.push_back(init_data[i*CFG_W +: CFG_W]);
         nack_plan.push_back(1'b0);
      end
      for (int a = 0; a <= MAX_RETRY; a++) begin
         exp_q.push_back(init_data[k*CFG_W +: CFG_W]);
         nack_plan.push_back(1'b1);
      end
      power = 1'b1;
      wait_state("init_err", ST_ERR, 600);
      chk("init_err.done", init_done, 0);
      cyc(30);
      chk_state("err_hold", ST_ERR);
      check_words("init_err");
      power = 1'b0;
      cyc(1);
      chk_state("err_exit", ST_IDLE);

      // Record with a pause in the middle, then stop.
      power = 1'b1;
      wait_state("pwr_rec", ST_STOP, 400);
      got_q.delete();
      rec_sel = 1'b1; run = 1'b1;
      cyc(1);
      chk_state("rec_enter", ST_REC);
      chk("rec_enter.len", rec_len, 0);
      n1 = $urandom_range(3, 6);
      n2 = $urandom_range(3, 6);
      m_len = 0;
      for (int i = 0; i < n1; i++) begin
         pulse_tick(); m_len++;
         chk("rec.addr", addr, m_len);
         chk("rec.len", rec_len, m_len);
         gap();
      end
      run = 1'b0;
      pulse_tick(); m_len++;
      chk_state("rec_pause", ST_RPAUSE);
      chk("rec_pause_tick.addr", addr, m_len);
      repeat (3) begin pulse_tick(); gap(); end
      chk("rec_frozen.addr", addr, m_len);
      chk("rec_frozen.len", rec_len, m_len);
      run = 1'b1;
      cyc(1);
      chk_state("rec_resume", ST_REC);
      for (int i = 0; i < n2; i++) begin
         pulse_tick(); m_len++;
         chk("rec2.addr", addr, m_len);
         chk("rec2.len", rec_len, m_len);
         gap();
      end
      rec_sel = 1'b0;
      cyc(1);
      chk_state("rec_stop", ST_STOP);
      chk("rec_stop.addr", addr, 0);
      chk("rec_stop.len", rec_len, m_len);

      // Play the clip with a pause; last sample ends playback.
      play_sel = 1'b1;
      cyc(1);
      chk_state("play_enter", ST_PLAY);
      chk("play_enter.addr", addr, 0);
      p = $urandom_range(2, m_len - 2);
      m_pos = 0;
      for (int i = 0; i < p - 1; i++) begin
         pulse_tick(); m_pos++;
         chk("play.addr", addr, m_pos);
         gap();
      end
      run = 1'b0;
      pulse_tick(); m_pos++;
      chk_state("play_pause", ST_PPAUSE);
      chk("play_pause_tick.addr", addr, m_pos);
      repeat (3) begin pulse_tick(); gap(); end
      chk("play_frozen.addr", addr, m_pos);
      run = 1'b1;
      cyc(1);
      chk_state("play_resume", ST_PLAY);
      while (m_pos < m_len - 1) begin
         pulse_tick(); m_pos++;
         chk("play2.addr", addr, m_pos);
         chk("play2.state", state, ST_PLAY);
         gap();
      end
      pulse_tick();
      chk_state("clip_end", ST_STOP);
      chk("clip_end.addr", addr, 0);
      chk("clip_end.len", rec_len, m_len);
      play_sel = 1'b0; run = 1'b0;
      cyc(1);

      // Fill the 16-entry memory: auto-stop with the full length kept.
      rec_sel = 1'b1; run = 1'b1;
      cyc(1);
      chk_state("full_enter", ST_REC);
      chk("full_enter.len", rec_len, 0);
      for (int i = 1; i <= (1 << ADDR_W); i++) begin
         pulse_tick();
         if (i < (1 << ADDR_W)) begin
            chk("full.addr", addr, i);
            gap();
         end
      end
      chk_state("full", ST_STOP);
      chk("full.len", rec_len, 1 << ADDR_W);
      chk("full.addr0", addr, 0);
      rec_sel = 1'b0; run = 1'b0;
      cyc(3);
      chk("full_kept.len", rec_len, 1 << ADDR_W);

      // Empty recording: play request must not leave stop.
      rec_sel = 1'b1; run = 1'b1;
      cyc(1);
      rec_sel = 1'b0;
      cyc(1);
      chk_state("empty_rec", ST_STOP);
      chk("empty_rec.len", rec_len, 0);
      play_sel = 1'b1;
      cyc(5);
      chk_state("play_zero", ST_STOP);
      play_sel = 1'b0;

      // Power drop mid-play: idle, address cleared, length kept.
      rec_sel = 1'b1;
      cyc(1);
      m_len = $urandom_range(3, 8);
      for (int i = 0; i < m_len; i++) pulse_tick();
      rec_sel = 1'b0;
      cyc(1);
      play_sel = 1'b1;
      cyc(1);
      chk_state("drop_play_enter", ST_PLAY);
      pulse_tick(); pulse_tick();
      power = 1'b0;
      cyc(1);
      chk_state("drop_play", ST_IDLE);
      chk("drop_play.addr", addr, 0);
      chk("drop_play.done", init_done, 0);
      chk("drop_play.len", rec_len, m_len);
      play_sel = 1'b0; run = 1'b0;

      // Power drop mid-init: the late finished pulse is ignored.
      got_q.delete();
      power = 1'b1;
      wt = 0;
      while (got_q.size() == 0 && wt < 50) begin
         @(negedge clk);
         wt++;
      end
      chk("mid_init.started", got_q.size(), 1);
      power = 1'b0;
      cyc(1);
      chk_state("mid_init_off", ST_IDLE);
      cyc(12);
      chk_state("late_fin", ST_IDLE);
      chk("late_fin.starts", got_q.size(), 1);
      chk("late_fin.len", rec_len, m_len);
      chk("late_fin.done", init_done, 0);

      // Reset while recording clears every output.
      power = 1'b1;
      wait_state("pwr_rst", ST_STOP, 400);
      rec_sel = 1'b1; run = 1'b1;
      cyc(1);
      repeat (3) pulse_tick();
      rst_n = 1'b0;
      cyc(1);
      chk_state("rst_rec", ST_IDLE);
      chk("rst_rec.addr", addr, 0);
      chk("rst_rec.len", rec_len, 0);
      chk("rst_rec.done", init_done, 0);
      chk("rst_rec.start", i2c_start, 0);
      chk("rst_rec.dat", i2c_dat, 0);
      rst_n = 1'b1; power = 1'b0; rec_sel = 1'b0; run = 1'b0;
      cyc(2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
